// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR round-robin scheduler.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 64;
    localparam logic [7:0]  TAPS8      = 8'hB8;
    localparam logic [7:0]  SEED8      = 8'h01;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } fsm_t;

    // One Fibonacci step on a zero-extended state; the caller truncates to its width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_rr_sched_if.sv
// Request/grant and seed-load bundle between the scheduler and its consumers.
interface lfsr_rr_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    logic               seed_we;
    logic [WIDTH-1:0]   seed;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   rnd;
    logic               ready;
    logic               lockup_err;

    modport master (
        output seed_we, seed, req,
        input  gnt, rnd, ready, lockup_err
    );

    modport slave (
        input  seed_we, seed, req,
        output gnt, rnd, ready, lockup_err
    );
endinterface

// File: rtl/lfsr_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr.
module lfsr_rr_arb #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + (NUM_REQ - 1 - k)) % NUM_REQ;
            if (req[PW'(idx)]) begin
                winner  = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_rr_sched.sv
// LFSR sequencer/arbiter: seeding, warm-up stepping and round-robin grants.
// Optional macro LFSR_LOCKUP_CHECK_EN adds zero-state recovery and a sticky lockup_err.
module lfsr_rr_sched
    import lfsr_pkg::*;
#(
    parameter int unsigned      NUM_REQ = 4,
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] TAPS    = TAPS8,
    parameter logic [WIDTH-1:0] SEED    = SEED8,
    parameter int unsigned      WARMUP  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_rr_sched_if.slave       bus
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_rr_sched: SEED must be non-zero");
    end

    fsm_t               fsm;
    logic [WIDTH-1:0]   state;
    logic [CW-1:0]      warm_cnt;
    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [WIDTH-1:0]   rnd;
    logic               ready;
    logic               lockup_err;

    logic [PW-1:0]      winner;
    logic               any_req;
    logic [WIDTH-1:0]   state_step;
    logic [PW-1:0]      ptr_next;

    lfsr_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next LFSR value and the pointer slot after the current winner.
    always_comb begin
        state_step = WIDTH'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));
        ptr_next   = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
    end

    // Sequencer: reset > seed load > lockup recovery > warm-up/serve.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SEED;
            fsm        <= ST_WARMUP;
            warm_cnt   <= '0;
            rr_ptr     <= '0;
            gnt        <= '0;
            rnd        <= '0;
            ready      <= 1'b0;
            lockup_err <= 1'b0;
        end else if (bus.seed_we) begin
            state    <= (bus.seed == '0) ? SEED : bus.seed;
            fsm      <= ST_WARMUP;
            warm_cnt <= '0;
            gnt      <= '0;
            ready    <= 1'b0;
`ifdef LFSR_LOCKUP_CHECK_EN
        end else if (state == '0) begin
            state      <= SEED;
            fsm        <= ST_WARMUP;
            warm_cnt   <= '0;
            gnt        <= '0;
            ready      <= 1'b0;
            lockup_err <= 1'b1;
`endif
        end else begin
            gnt <= '0;
            case (fsm)
                ST_WARMUP: begin
                    ready <= 1'b0;
                    if (WARMUP == 0) begin
                        fsm   <= ST_SERVE;
                        ready <= 1'b1;
                    end else begin
                        state <= state_step;
                        if (warm_cnt == CW'(WARMUP - 1)) begin
                            fsm      <= ST_SERVE;
                            ready    <= 1'b1;
                            warm_cnt <= '0;
                        end else begin
                            warm_cnt <= warm_cnt + CW'(1);
                        end
                    end
                end
                ST_SERVE: begin
                    ready <= 1'b1;
                    if (any_req) begin
                        gnt    <= NUM_REQ'(1) << winner;
                        rnd    <= state;
                        state  <= state_step;
                        rr_ptr <= ptr_next;
                    end
                end
                default: begin
                    fsm   <= ST_WARMUP;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs onto the bus.
    always_comb begin
        bus.gnt        = gnt;
        bus.rnd        = rnd;
        bus.ready      = ready;
        bus.lockup_err = lockup_err;
    end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Scoreboard bench for lfsr_rr_sched (defaults: 4 requesters, 8-bit, taps B8, seed 01, warm-up 8).
module tb_lfsr_rr_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 8;

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [W-1:0]  rnd;
        logic          ready;
        logic          lerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests  = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model state
    logic [W-1:0]  m_state = 8'h01;
    logic          m_serve = 1'b0;
    int            m_cnt   = 0;
    int            m_ptr   = 0;
    logic [NR-1:0] m_gnt   = '0;
    logic [W-1:0]  m_rnd   = '0;
    logic          m_ready = 1'b0;
    logic          m_lerr  = 1'b0;

    always #5 clk = ~clk;

    lfsr_rr_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    lfsr_rr_sched #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .TAPS    (8'hB8),
        .SEED    (8'h01),
        .WARMUP  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
        logic fb;
        fb = ^(s & 8'hB8);
        return {s[W-2:0], fb};
    endfunction

    // Drive one cycle of inputs, predict the registered outputs, wait for them.
    task automatic drive(input logic r, input logic sw, input logic [W-1:0] sd, input logic [NR-1:0] rq);
        exp_t e;
        int   w;
        bit   found;
        rst         = r;
        bus.seed_we = sw;
        bus.seed    = sd;
        bus.req     = rq;
        found = 0;
        w     = 0;
        if (!r) begin
            m_state = 8'h01; m_serve = 0; m_cnt = 0; m_ptr = 0;
            m_gnt = '0; m_rnd = '0; m_ready = 0; m_lerr = 0;
        end else if (sw) begin
            m_state = (sd == 0) ? 8'h01 : sd;
            m_serve = 0; m_cnt = 0; m_gnt = '0; m_ready = 0;
        end else if (!m_serve) begin
            m_gnt   = '0;
            m_ready = 0;
            m_state = ref_step(m_state);
            if (m_cnt == 7) begin
                m_serve = 1; m_ready = 1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_ready = 1;
            m_gnt   = '0;
            for (int o = 0; o < NR; o++) begin
                if (!found && rq[(m_ptr + o) % NR]) begin
                    w     = (m_ptr + o) % NR;
                    found = 1;
                end
            end
            if (found) begin
                m_gnt   = NR'(1) << w;
                m_rnd   = m_state;
                m_state = ref_step(m_state);
                m_ptr   = (w + 1) % NR;
            end
        end
        e = '{gnt: m_gnt, rnd: m_rnd, ready: m_ready, lerr: m_lerr};
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Scoreboard: pop the oldest prediction once its outputs have settled.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            tests++;
            if ({bus.gnt, bus.rnd, bus.ready, bus.lockup_err} !== {e.gnt, e.rnd, e.ready, e.lerr}) begin
                errors++;
                $display("FAIL scoreboard @%0t: gnt=%b rnd=%h ready=%b lerr=%b, required gnt=%b rnd=%h ready=%b lerr=%b",
                         $time, bus.gnt, bus.rnd, bus.ready, bus.lockup_err, e.gnt, e.rnd, e.ready, e.lerr);
            end
        end
    end

    task automatic test_reset();
        drive(0, 0, 8'h00, 4'h0);
        drive(0, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'h0 || bus.rnd !== 8'h00 || bus.ready !== 1'b0 || bus.lockup_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: gnt=%b rnd=%h ready=%b lerr=%b, required 0000/00/0/0",
                     bus.gnt, bus.rnd, bus.ready, bus.lockup_err);
        end
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 7; i++) drive(1, 0, 8'h00, 4'h0);
        tests++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL warmup_ready_early: ready=%b, required 0", bus.ready);
        end
        drive(1, 0, 8'h00, 4'h0);
        tests++;
        if (bus.ready !== 1'b1 || bus.gnt !== 4'h0 || bus.rnd !== 8'h00) begin
            errors++;
            $display("FAIL warmup_done: ready=%b gnt=%b rnd=%h, required 1/0000/00", bus.ready, bus.gnt, bus.rnd);
        end
    endtask

    task automatic test_all_req();
        logic [NR-1:0] eg [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [W-1:0]  er [4] = '{8'h1C, 8'h38, 8'h71, 8'hE2};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h00, 4'hF);
            tests++;
            if (bus.gnt !== eg[i] || bus.rnd !== er[i]) begin
                errors++;
                $display("FAIL all_req[%0d]: gnt=%b rnd=%h, required %b/%h", i, bus.gnt, bus.rnd, eg[i], er[i]);
            end
        end
    endtask

    task automatic test_single_hold();
        logic [W-1:0] er [3] = '{8'hC4, 8'h89, 8'h12};
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h00, 4'b0100);
            tests++;
            if (bus.gnt !== 4'b0100 || bus.rnd !== er[i]) begin
                errors++;
                $display("FAIL single_hold[%0d]: gnt=%b rnd=%h, required 0100/%h", i, bus.gnt, bus.rnd, er[i]);
            end
        end
        drive(1, 0, 8'h00, 4'b0101);
        tests++;
        if (bus.gnt !== 4'b0001 || bus.rnd !== 8'h25) begin
            errors++;
            $display("FAIL ptr_wrap: gnt=%b rnd=%h, required 0001/25", bus.gnt, bus.rnd);
        end
    endtask

    task automatic test_seed_zero();
        drive(1, 1, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'h0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL seed_drop_grant: gnt=%b ready=%b, required 0000/0", bus.gnt, bus.ready);
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 4'hF);
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'b0010 || bus.rnd !== 8'h1C) begin
            errors++;
            $display("FAIL seed_zero_subst: gnt=%b rnd=%h, required 0010/1C", bus.gnt, bus.rnd);
        end
    endtask

    task automatic test_seed_mid();
        drive(1, 1, 8'h47, 4'hF);
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 4'hF);
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'b0100 || bus.rnd !== 8'h12) begin
            errors++;
            $display("FAIL seed_47_first: gnt=%b rnd=%h, required 0100/12", bus.gnt, bus.rnd);
        end
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'b1000 || bus.rnd !== 8'h25) begin
            errors++;
            $display("FAIL seed_47_second: gnt=%b rnd=%h, required 1000/25", bus.gnt, bus.rnd);
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 8'h47, 4'h0);
        for (int i = 0; i < 3; i++) drive(1, 0, 8'h00, 4'h0);
        drive(0, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'h0 || bus.rnd !== 8'h00 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_warmup: gnt=%b rnd=%h ready=%b, required 0000/00/0", bus.gnt, bus.rnd, bus.ready);
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 4'h0);
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'b0001 || bus.rnd !== 8'h1C) begin
            errors++;
            $display("FAIL after_reset_grant: gnt=%b rnd=%h, required 0001/1C", bus.gnt, bus.rnd);
        end
        drive(0, 0, 8'h00, 4'hF);
        tests++;
        if (bus.gnt !== 4'h0 || bus.rnd !== 8'h00 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_flight: gnt=%b rnd=%h ready=%b, required 0000/00/0", bus.gnt, bus.rnd, bus.ready);
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 4'h0);
    endtask

    task automatic test_lockup();
`ifdef LFSR_LOCKUP_CHECK_EN
        bus.req = 4'h0;
        #1;
        force dut.state = 8'h00;
        #1;
        release dut.state;
        @(negedge clk);
        tests++;
        if (bus.lockup_err !== 1'b1 || bus.ready !== 1'b0 || bus.gnt !== 4'h0) begin
            errors++;
            $display("FAIL lockup_recover: lerr=%b ready=%b gnt=%b, required 1/0/0000", bus.lockup_err, bus.ready, bus.gnt);
        end
        m_state = 8'h01; m_serve = 0; m_cnt = 0; m_gnt = '0; m_ready = 0; m_lerr = 1;
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h00, 4'h0);
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.rnd !== 8'h1C || bus.lockup_err !== 1'b1) begin
            errors++;
            $display("FAIL lockup_sticky: rnd=%h lerr=%b, required 1C/1", bus.rnd, bus.lockup_err);
        end
        drive(0, 0, 8'h00, 4'h0);
        tests++;
        if (bus.lockup_err !== 1'b0) begin
            errors++;
            $display("FAIL lockup_clear: lerr=%b, required 0", bus.lockup_err);
        end
`else
        drive(1, 0, 8'h00, 4'hF);
        tests++;
        if (bus.lockup_err !== 1'b0) begin
            errors++;
            $display("FAIL lockup_tied: lerr=%b, required 0", bus.lockup_err);
        end
`endif
    endtask

    initial begin
        bus.seed_we = 1'b0;
        bus.seed    = '0;
        bus.req     = '0;
        test_reset();
        test_warmup();
        test_all_req();
        test_single_hold();
        test_seed_zero();
        test_seed_mid();
        test_reset_mid();
        test_lockup();
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rr_sched.md
Name: lfsr_rr_sched

Overview:
Sequencer and arbiter that owns one Fibonacci LFSR and shares its output among NUM_REQ requesters.
- Handles seeding, post-seed warm-up stepping and round-robin granting.
- Guarantees the all-zero lockup state is never loaded.
- Sits between the pseudo-random source and its consumers (scramblers, test-pattern generators); each grant consumes exactly one LFSR step.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, LFSR width in bits
TAPS, 8'hB8, feedback tap mask (x^8+x^6+x^5+x^4+1, maximal length, period 255)
SEED, 8'h01, reset/substitute seed; must be non-zero (elaboration error otherwise)
WARMUP, 8, LFSR steps discarded after reset or seed load (0 = none)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
seed_we  in  1  load seed this cycle
seed  in  WIDTH  seed value
req  in  NUM_REQ  level requests, one bit per requester
gnt  out  NUM_REQ  registered one-hot grant pulse, 1 cycle
rnd  out  WIDTH  registered random word; valid when |gnt
ready  out  1  high in SERVE state
lockup_err  out  1  sticky lockup flag (tied 0 without macro)

Behaviour:
- Reset interface: rst and clk only; reset is synchronous, active-low.
- Reset values (rst==0 at a clk edge):
  - state=SEED, fsm=WARMUP, warm_cnt=0, rr_ptr=0.
  - gnt=0, rnd=0, ready=0, lockup_err=0.
- LFSR step:
  - fb = ^(state & TAPS)
  - state_next = {state[WIDTH-2:0], fb}
  - From 0x01 with TAPS=0xB8: 01,02,04,08,11,23,47,8E,1C,38,71,E2...
- FSM WARMUP:
  - Steps the LFSR every cycle; warm_cnt increments.
  - When warm_cnt==WARMUP-1 on a step, go to SERVE. WARMUP=0 goes to SERVE on the next cycle.
  - gnt=0 throughout; req ignored, not queued.
- FSM SERVE:
  - ready=1.
  - Each cycle with |req, the arbiter selects the first asserted req at or after rr_ptr (wrapping).
  - At the edge: gnt=onehot(winner), rnd=state (pre-step value), state steps, rr_ptr=(winner+1) mod NUM_REQ.
  - No req: gnt=0, rnd holds, state holds, rr_ptr holds.
  - Latency: req sampled at edge t gives gnt/rnd valid in cycle t+1.
  - A requester holding req continuously with others idle is granted every cycle.
- Seed load (seed_we=1, any state):
  - state = (seed==0) ? SEED : seed; warm_cnt=0; fsm=WARMUP.
  - gnt=0 and ready=0 next cycle; a grant that would have issued in that cycle is dropped.
  - rr_ptr unchanged.
- Precedence: rst > seed_we > lockup recovery > normal operation.
- Reset mid-operation: everything returns to reset values on the same edge; any in-flight gnt is cleared.
- rnd never equals 0 in SERVE.

Optional Feature:
Macro LFSR_LOCKUP_CHECK_EN.
- Defined:
  - If state==0 at an edge (not reachable functionally; covers SEU or forced state), reload SEED, fsm=WARMUP, warm_cnt=0, gnt=0.
  - Set lockup_err=1, which stays set until rst.
- Undefined: no check logic; lockup_err tied 0; zero state persists if ever forced.

Decomposition:
- Package lfsr_pkg:
  - fsm enum {WARMUP, SERVE}
  - default TAPS8=8'hB8
  - default SEED8=8'h01
  - step function lfsr_step(state, taps)
- Sub-module lfsr_rr_arb: combinational round-robin pick.
  - Inputs: req, rr_ptr.
  - Outputs: winner index, any_req.
  - Pointer register stays in the parent.

Test Plan:
- Reset with defaults, req=0: ready rises after 8 warm-up cycles, then state=0x1C; gnt=0 and rnd=0 throughout.
- Then req=4'b1111 for 4 cycles: gnt=0001,0010,0100,1000 with rnd=1C,38,71,E2; rr_ptr wraps to 0.
- req=4'b0100 held 3 cycles in SERVE: gnt=0100 every cycle with consecutive distinct LFSR values; then req=4'b0101 gives gnt=0001 (pointer at 3, wrap).
- seed_we=1, seed=0x00 with req=4'b1111 in the same cycle: no grant, ready drops; after 8 cycles state=0x1C (SEED substituted).
- seed_we with seed=0x47 mid-stream: after warm-up, rnd sequence continues from the 8th successor of 0x47; reset asserted mid-warm-up gives reset values on the same edge.
- With LFSR_LOCKUP_CHECK_EN: force state=0 for one cycle → next edge state=0x01, lockup_err=1, fsm=WARMUP; lockup_err stays 1 until rst=0. Without the macro: lockup_err stays 0.
